ram_bus_ctrl: RTL

Synchronous bus controller sitting directly upstream of the asynchronous 32K×8 `ram` block. It accepts single-byte read/write requests from the CPU side over a valid/ready handshake and sequences the RAM's `address`, active-low `write` strobe and shared tri-state `data` bus. The sequence is setup, strobe and hold, so the RAM never sees address or data change while `write` is low. Read data is captured from the shared bus and returned with a one-cycle response pulse.

---
 rtl/ram_bus_ctrl_if.sv | 15 +
 rtl/ram_bus_ctrl.sv | 64 ++++++
 2 files changed

// File: rtl/ram_bus_ctrl_if.sv
// ram_bus_ctrl_if: CPU-side request/response handshake of ram_bus_ctrl
interface ram_bus_ctrl_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_write;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  modport master (output req_valid, req_addr, req_write, req_wdata, input req_ready, resp_valid, resp_rdata);
  modport slave (input req_valid, req_addr, req_write, req_wdata, output req_ready, resp_valid, resp_rdata);
endinterface

// File: rtl/ram_bus_ctrl.sv
// ram_bus_ctrl: sequences single-byte requests onto the async RAM as setup, strobe, hold
module ram_bus_ctrl #(
  parameter int ADDR_WIDTH  = 15,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_bus_ctrl_if.slave         bus,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, STROBE = 2'd2, HOLD = 2'd3;
  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic                  wr_q, wr_d, we_n_q, we_n_d, oe_q, oe_d, resp_q, resp_d;
  logic                  accept, last;
  assign accept = bus.req_valid && state_q == IDLE;
  assign last   = state_q == STROBE && cnt_q == CW'(1);
  always_comb begin
    state_d = accept ? SETUP : state_q == SETUP ? STROBE : last ? HOLD : state_q == HOLD ? IDLE : state_q;
    cnt_d   = state_q == SETUP ? CW'(WAIT_CYCLES) : state_q == STROBE ? cnt_q - CW'(1) : cnt_q;
    addr_d  = accept ? bus.req_addr : addr_q;
    wr_d    = accept ? bus.req_write : wr_q;
    wdata_d = accept ? bus.req_wdata : wdata_q;
    // strobe is low for the registered cycles following SETUP up to and including the last STROBE cycle
    we_n_d  = !(wr_q && (state_q == SETUP || (state_q == STROBE && !last)));
    oe_d    = accept ? bus.req_write : state_q == HOLD ? 1'b0 : oe_q;
    resp_d  = last;
    rdata_d = (last && !wr_q) ? mem_data : rdata_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_n_q  <= we_n_d;
      oe_q    <= oe_d;
      resp_q  <= resp_d;
    end
  assign bus.req_ready  = state_q == IDLE;
  assign bus.resp_valid = resp_q;
  assign bus.resp_rdata = rdata_q;
  assign mem_address    = addr_q;
  assign mem_write      = we_n_q;
  assign mem_data       = oe_q ? wdata_q : 'z;
endmodule
